// File: rtl/serial_subtractor.sv
// serial_subtractor: computes a - b one bit per clock, LSB first, as a + ~b + 1.
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous, active-high reset
//   start    begin a subtraction (accepted in IDLE or DONE, ignored in RUN)
//   a, b     minuend / subtrahend, captured only on an accepted start
//   busy     high while the FSM is in RUN
//   done     one-cycle pulse while the FSM is in DONE (new result valid)
//   diff     registered a - b modulo 2^WIDTH, held until the next completion
//   overflow signed overflow of the last completed subtraction
//   borrow   unsigned borrow (a < b) of the last completed subtraction
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             overflow,
  output logic             borrow
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_q, diff_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, ovf_q, brw_q;

  // One full-adder slice on the current LSBs, subtrahend inverted.
  logic a_bit, nb_bit, sum_bit, cout, last_bit;
  assign a_bit    = a_q[0];
  assign nb_bit   = ~b_q[0];
  assign sum_bit  = a_bit ^ nb_bit ^ carry_q;
  assign cout     = (a_bit & nb_bit) | (a_bit & carry_q) | (nb_bit & carry_q);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      brw_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b1;  // the "+1" of the two's complement negate
          end
        end
        RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          res_q   <= {sum_bit, res_q[WIDTH-1:1]};
          carry_q <= cout;
          cnt_q   <= cnt_q + CW'(1);
          if (last_bit) begin
            // carry_q is the carry into the MSB, cout the carry out of it.
            diff_q <= {sum_bit, res_q[WIDTH-1:1]};
            brw_q  <= ~cout;
            ovf_q  <= carry_q ^ cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign diff     = diff_q;
  assign overflow = ovf_q;
  assign borrow   = brw_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized + directed bench for serial_subtractor with a queue scoreboard.
// The stimulus side pushes expected results (computed with integer arithmetic)
// and the cycle on which done must appear; the monitor pops on every done.
module tb_serial_subtractor;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] a, b;
  logic         busy, done, overflow, borrow;
  logic [W-1:0] diff;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .overflow(overflow), .borrow(borrow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         o;
    logic         br;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Reference: plain integer subtraction, range check for signed overflow.
  function automatic exp_t model(input int ai, input int bi, input int c);
    exp_t e;
    int sa, sbv, s;
    sa  = (ai >= 2 ** (W - 1)) ? ai - 2 ** W : ai;
    sbv = (bi >= 2 ** (W - 1)) ? bi - 2 ** W : bi;
    s   = sa - sbv;
    e.d   = W'(ai - bi);
    e.br  = (ai < bi);
    e.o   = (s > 2 ** (W - 1) - 1) || (s < -(2 ** (W - 1)));
    e.cyc = c;
    return e;
  endfunction

  // Called just after a negedge: present start; capture edge is cyc+1,
  // so done must be visible right after edge cyc+1+W.
  task automatic issue(input int ai, input int bi);
    a = W'(ai);
    b = W'(bi);
    start = 1'b1;
    sb.push_back(model(ai, bi, cyc + 1 + W));
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 3 * W + 4; k++) begin
      if (done) return;
      @(negedge clk);
    end
    vectors++;
    miscompares++;
    $display("FAIL wait_done: got timeout want done within %0d cycles", 3 * W + 4);
  endtask

  // Monitor, sampled 1 time unit after each rising edge.
  initial begin
    exp_t         e;
    logic [W-1:0] hold_d = '0;
    logic         hold_o = 1'b0, hold_b = 1'b0;
    int           busy_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        hold_d = '0; hold_o = 1'b0; hold_b = 1'b0;
        busy_cnt = 0;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
      end else begin
        if (busy) busy_cnt++;
        if (done) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("diff", 32'(diff), 32'(e.d));
            chk("overflow", 32'(overflow), 32'(e.o));
            chk("borrow", 32'(borrow), 32'(e.br));
            chk("done_cycle", 32'(cyc), 32'(e.cyc));
            chk("busy_cycles", 32'(busy_cnt), W);
            hold_d = e.d; hold_o = e.o; hold_b = e.br;
          end
          busy_cnt = 0;
        end
        chk("busy_and_done", 32'(busy & done), 0);
      end
      chk("hold_diff", 32'(diff), 32'(hold_d));
      chk("hold_flags", {30'd0, overflow, borrow}, {30'd0, hold_o, hold_b});
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("reset_state", {busy, done, overflow, borrow, 28'(diff)}, 0);
    rst = 1'b0;

    // Directed arithmetic cases
    issue(5, 3);  wait_done();
    issue(3, 5);  wait_done();
    issue(7, 15); wait_done();
    issue(8, 1);  wait_done();

    // start re-pulsed mid-RUN with different operands is ignored
    issue(2, 9);
    start = 1'b1; a = 4'hF; b = 4'h0;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // start during DONE: back-to-back, done pulses W+1 edges apart
    issue(6, 2);  wait_done();
    issue(1, 12); wait_done();

    // reset on the 2nd RUN cycle aborts; start on first edge after reset
    issue(4, 4);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    issue(9, 3);  wait_done();

    // Exhaustive sweep
    for (int ai = 0; ai < 2 ** W; ai++)
      for (int bi = 0; bi < 2 ** W; bi++) begin
        issue(ai, bi);
        wait_done();
      end

    // Random operands, gaps and ignored mid-RUN starts
    for (int n = 0; n < 100; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue($urandom_range(0, 2 ** W - 1), $urandom_range(0, 2 ** W - 1));
      if ($urandom_range(0, 3) == 0) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      wait_done();
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  rising-edge clock; the single clock of the block.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request to begin a subtraction; sampled on the rising clk edge.
REQ-005 SHALL have port a  input  WIDTH  minuend, two's complement; captured only on an accepted start.
REQ-006 SHALL have port b  input  WIDTH  subtrahend, two's complement; captured only on an accepted start.
REQ-007 SHALL have port busy  output  1  high while a subtraction is in progress.
REQ-008 SHALL have port done  output  1  single-cycle pulse marking a new valid result.
REQ-009 SHALL have port diff  output  WIDTH  registered result a - b, modulo 2^WIDTH.
REQ-010 SHALL have port overflow  output  1  signed overflow of the last completed subtraction.
REQ-011 SHALL have port borrow  output  1  unsigned borrow (a < b as unsigned) of the last completed subtraction.

Function
REQ-012 SHALL implement an FSM with states IDLE, RUN, DONE.
REQ-013 SHALL compute a - b bit-serially, LSB first, one bit per clk: a + ~b + 1, carry register preset to 1 on capture.
REQ-014 SHALL, in IDLE or DONE with start=1, capture a and b into shift registers, clear the bit counter, preset carry=1, and enter RUN.
REQ-015 SHALL, in RUN, process one bit per edge: sum = a_bit ^ ~b_bit ^ carry; next carry = majority(a_bit, ~b_bit, carry); shift sum into the result register from the MSB side.
REQ-016 SHALL leave RUN for DONE on the edge that processes bit WIDTH-1, i.e. exactly WIDTH edges after the capture edge.
REQ-017 SHALL, on the RUN->DONE edge, load diff with the completed result, borrow with ~carry_out, and overflow with carry_into_MSB ^ carry_out.
REQ-018 SHALL assert done for exactly the one cycle the FSM is in DONE; DONE returns to IDLE on the next edge unless start=1, in which case it goes to RUN.
REQ-019 SHALL assert busy exactly while in RUN; busy and done are never high together.
REQ-020 SHALL ignore start while in RUN; a, b and the in-flight operation are unaffected.
REQ-021 SHALL hold diff, overflow and borrow stable from one completion to the next, including throughout RUN.
REQ-022 SHALL give a start-to-done latency of WIDTH+1 edges: capture edge, then WIDTH bit edges; done is visible after the last of these.
REQ-023 SHALL ignore a and b changes at any time other than the accepted start edge.

Reset
REQ-024 SHALL, when rst=1 on a clk edge, enter IDLE and set busy=0, done=0, diff=0, overflow=0, borrow=0, and clear the counter, carry and shift registers.
REQ-025 SHALL give rst priority over start and over any in-flight operation; an aborted subtraction produces no done pulse and no result update.
REQ-026 SHALL accept start on the first edge after rst deasserts.

Verification (WIDTH=4)
REQ-027 SHALL cover: a=0101, b=0011, start pulse -> done after 5 edges, diff=0010, overflow=0, borrow=0; busy high for 4 cycles.
REQ-028 SHALL cover: a=0011, b=0101 -> diff=1110, overflow=0, borrow=1.
REQ-029 SHALL cover overflow cases: a=0111, b=1111 -> diff=1000, overflow=1, borrow=1; a=1000, b=0001 -> diff=0111, overflow=1, borrow=0.
REQ-030 SHALL cover: start re-pulsed with new operands mid-RUN -> ignored, first result unchanged; start held high during DONE -> back-to-back operation, done pulses 5 edges apart.
REQ-031 SHALL cover: rst asserted on the 2nd RUN cycle -> busy=0 and all outputs 0 on the next edge, no done pulse; a following start completes normally.
REQ-032 SHALL cover: exhaustive sweep of all 256 (a, b) pairs against a golden model of diff, overflow and borrow, with zero mismatches.
